// File: rtl/clock_manager_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_manager_pkg
// Description : Shared encodings for the clock manager: operating modes,
//               reset-sequencer states and the slow-divider wrap helper.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_manager_pkg;

  // Operating mode as presented on mode_i
  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_SLOW = 2'b01,
    MODE_STEP = 2'b10,
    MODE_HALT = 2'b11
  } mode_e;

  // Reset sequencer states
  typedef enum logic [1:0] {
    SEQ_HOLD    = 2'b00,
    SEQ_RELEASE = 2'b01,
    SEQ_ACTIVE  = 2'b10
  } seq_state_e;

  // True on the cycle a divider counter completes its period.
  // Ratios 0 and 1 both mean "every cycle".
  function automatic logic div_wrap(input logic [31:0] cnt, input logic [31:0] div);
    return (div <= 32'd1) || (cnt >= div - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_manager_step_debounce.sv
`default_nettype none
// ============================================================================
// Module      : step_debounce
// Description : Two-flop synchroniser followed by a counter debouncer for the
//               raw single-step button. The stable level flips only after the
//               synchronised input has disagreed with it for 2^DEB_W
//               consecutive cycles; rise pulses for one cycle on a 0->1 flip.
// Revision    : 1.0 - initial release
// ============================================================================
module step_debounce #(
  parameter int DEB_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_in,
  output logic stable,
  output logic rise
);

  logic [1:0]       r_sync;
  logic [DEB_W-1:0] r_cnt;

  // Bring the asynchronous button into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[0], step_in};
  end

  // Count consecutive disagreeing cycles; any agreement restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (r_sync[1] == stable) begin
        r_cnt <= '0;
      end else if (&r_cnt) begin
        r_cnt  <= '0;
        stable <= r_sync[1];
        rise   <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/clock_manager.sv
`default_nettype none
// ============================================================================
// Module      : clock_manager
// Description : Staggered per-channel reset release plus per-channel clock
//               enable generation (RUN / SLOW divider / debounced STEP / HALT).
//               Channels held in reset always see ce_o high so enable-gated
//               synchronous reset logic observes the reset.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_manager
  import clock_manager_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int DIV_W   = 16,
  parameter int HOLD    = 65535,
  parameter int STAGGER = 4,
  parameter int DEB_W   = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [1:0]           mode_i,
  input  logic [NCH*DIV_W-1:0] div_i,
  input  logic                 step_i,
  input  logic                 soft_rst_i,
  output logic [NCH-1:0]       ce_o,
  output logic [NCH-1:0]       rstn_o,
  output logic                 ready_o
);

  localparam int C_HOLD_W = $clog2(HOLD + 1);
  localparam int C_STG_W  = (STAGGER > 1) ? $clog2(STAGGER) : 1;

  logic [1:0]          r_rsync;
  seq_state_e          r_state;
  seq_state_e          w_state_d;
  logic [C_HOLD_W-1:0] r_hold_cnt;
  logic [C_STG_W-1:0]  r_stg_cnt;
  logic                w_stg_wrap;
  logic [NCH-1:0]      r_rstn;
  logic [NCH-1:0]      w_rstn_d;
  logic [NCH-1:0]      r_ce;
  logic [NCH-1:0]      w_en_d;
  logic [NCH-1:0]      w_slow_pulse;
  logic                r_ready;
  mode_e               r_mode;
  logic                w_slow_entry;
  logic                w_step_level;
  logic                w_step_rise;
  logic                w_step_fire;

  assign rstn_o  = r_rstn;
  assign ce_o    = r_ce;
  assign ready_o = r_ready;

  // Synchronise the release of the external reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rsync <= '0;
    else         r_rsync <= {r_rsync[0], 1'b1};
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= SEQ_HOLD;
    else         r_state <= w_state_d;
  end

  assign w_stg_wrap = (r_stg_cnt == C_STG_W'(STAGGER - 1));

  // Next state and next reset vector; releases form a thermometer from ch0 up
  always_comb begin
    w_state_d = r_state;
    w_rstn_d  = r_rstn;
    if (soft_rst_i) begin
      w_state_d = SEQ_HOLD;
      w_rstn_d  = '0;
    end else begin
      case (r_state)
        SEQ_HOLD: begin
          if (r_rsync[1] && (r_hold_cnt == C_HOLD_W'(HOLD - 1))) begin
            w_rstn_d  = NCH'(1);
            w_state_d = w_rstn_d[NCH-1] ? SEQ_ACTIVE : SEQ_RELEASE;
          end
        end
        SEQ_RELEASE: begin
          if (w_stg_wrap) begin
            w_rstn_d  = (r_rstn << 1) | NCH'(1);
            w_state_d = w_rstn_d[NCH-1] ? SEQ_ACTIVE : SEQ_RELEASE;
          end
        end
        SEQ_ACTIVE: begin
          w_state_d = SEQ_ACTIVE;
        end
        default: begin
          w_state_d = SEQ_HOLD;
          w_rstn_d  = '0;
        end
      endcase
    end
  end

  // Hold and stagger counters; soft reset keeps them cleared while asserted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hold_cnt <= '0;
      r_stg_cnt  <= '0;
    end else if (soft_rst_i) begin
      r_hold_cnt <= '0;
      r_stg_cnt  <= '0;
    end else begin
      if ((r_state == SEQ_HOLD) && r_rsync[1]) r_hold_cnt <= r_hold_cnt + 1'b1;
      if (r_state == SEQ_RELEASE) r_stg_cnt <= w_stg_wrap ? '0 : r_stg_cnt + 1'b1;
      else                        r_stg_cnt <= '0;
    end
  end

  // Mode is registered so a change reaches ce_o one edge after sampling
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_mode <= MODE_RUN;
    else         r_mode <= mode_e'(mode_i);
  end

  assign w_slow_entry = (mode_e'(mode_i) == MODE_SLOW) && (r_mode != MODE_SLOW);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             w_wrap;

    assign w_wrap          = div_wrap(32'(r_cnt), 32'(r_div));
    assign w_slow_pulse[k] = (r_mode == MODE_SLOW) && w_wrap;

    // Divider restarts on SLOW entry and reloads its ratio only at each wrap
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_cnt <= '0;
        r_div <= '0;
      end else if (w_slow_entry) begin
        r_cnt <= '0;
        r_div <= div_i[k*DIV_W +: DIV_W];
      end else if (r_mode == MODE_SLOW) begin
        if (w_wrap) begin
          r_cnt <= '0;
          r_div <= div_i[k*DIV_W +: DIV_W];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  step_debounce #(
    .DEB_W (DEB_W)
  ) u_step_debounce (
    .clk     (clk),
    .rst_n   (resetn),
    .step_in (step_i),
    .stable  (w_step_level),
    .rise    (w_step_rise)
  );

  // Step edges count only while fully active; others are simply dropped
  assign w_step_fire = w_step_rise && w_step_level && (r_state == SEQ_ACTIVE);

  // Enable pattern for released channels under the registered mode
  always_comb begin
    w_en_d = '0;
    case (r_mode)
      MODE_RUN:  w_en_d = '1;
      MODE_SLOW: w_en_d = w_slow_pulse;
      MODE_STEP: w_en_d = {NCH{w_step_fire}};
      default:   w_en_d = '0;
    endcase
  end

  // Output registers; channels in reset are forced enabled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstn  <= '0;
      r_ready <= 1'b0;
      r_ce    <= '1;
    end else begin
      r_rstn  <= w_rstn_d;
      r_ready <= w_rstn_d[NCH-1];
      r_ce    <= ~w_rstn_d | w_en_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_manager
// Description : Self-checking bench for clock_manager (NCH=3, HOLD=8,
//               STAGGER=4, DEB_W=2) with a schedule-based reference model and
//               directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_manager;
  import clock_manager_pkg::*;

  localparam int NCH     = 3;
  localparam int DIV_W   = 8;
  localparam int HOLD    = 8;
  localparam int STAGGER = 4;
  localparam int DEB_W   = 2;
  localparam int DEB_L   = 1 << DEB_W;
  localparam longint INF = 64'h3FFF_FFFF_FFFF;

  logic                 clk = 1'b0;
  logic                 clk_run = 1'b1;
  logic                 resetn = 1'b0;
  logic [1:0]           mode_i = 2'b00;
  logic [NCH*DIV_W-1:0] div_i = {8'd5, 8'd3, 8'd0};
  logic                 step_i = 1'b0;
  logic                 soft_rst_i = 1'b0;
  logic [NCH-1:0]       ce_o;
  logic [NCH-1:0]       rstn_o;
  logic                 ready_o;

  int tests = 0;
  int fails = 0;

  clock_manager #(
    .NCH(NCH), .DIV_W(DIV_W), .HOLD(HOLD), .STAGGER(STAGGER), .DEB_W(DEB_W)
  ) dut (
    .clk(clk), .resetn(resetn), .mode_i(mode_i), .div_i(div_i), .step_i(step_i),
    .soft_rst_i(soft_rst_i), .ce_o(ce_o), .rstn_o(rstn_o), .ready_o(ready_o)
  );

  always #5 if (clk_run) clk = ~clk;

  // ---------------- reference model ----------------
  longint         n = 0;
  longint         ref_e = INF;      // edge at which rstn_o[0] must rise
  bit             in_rst = 1'b1;
  logic [1:0]     mprev = 2'b00;
  logic [1:0]     eff;
  longint         nxt [NCH];
  logic [7:0]     win = '0;         // raw step samples, [0] = this edge
  longint         last_t = -100;
  bit             stab = 1'b0, rise_m = 1'b0, fire, differ;
  logic [NCH-1:0] pulse;
  logic [NCH-1:0] exp_ce = '1, exp_rstn = '0;
  logic           exp_ready = 1'b0;

  function automatic longint per(input logic [DIV_W-1:0] d);
    return (d <= 1) ? 64'd1 : longint'(d);
  endfunction

  function automatic void m_reset();
    ref_e = INF; in_rst = 1'b1; mprev = 2'b00; win = '0; stab = 1'b0;
    rise_m = 1'b0; last_t = -100; exp_rstn = '0; exp_ready = 1'b0; exp_ce = '1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, n);
    end
  endtask

  always @(negedge resetn) m_reset();

  // Advance the model one edge, then compare all outputs just after the edge
  always @(posedge clk) begin
    n = n + 1;
    if (!resetn) begin
      m_reset();
    end else begin
      eff  = mprev;
      fire = rise_m && exp_ready;
      if (in_rst) begin ref_e = n + 1 + HOLD; in_rst = 1'b0; end
      if (soft_rst_i) ref_e = n + HOLD;
      for (int k = 0; k < NCH; k++) exp_rstn[k] = (n >= ref_e + longint'(k * STAGGER));
      exp_ready = &exp_rstn;
      pulse = '0;
      for (int k = 0; k < NCH; k++) begin
        if (eff == MODE_SLOW) begin
          if (n == nxt[k]) begin
            pulse[k] = 1'b1;
            nxt[k] = n + per(div_i[k*DIV_W +: DIV_W]);
          end
        end else if (mode_i == MODE_SLOW) begin
          nxt[k] = n + per(div_i[k*DIV_W +: DIV_W]);
        end
      end
      for (int k = 0; k < NCH; k++)
        exp_ce[k] = !exp_rstn[k] || (eff == MODE_RUN) || ((eff == MODE_SLOW) && pulse[k])
                    || ((eff == MODE_STEP) && fire);
      win = {win[6:0], step_i};
      rise_m = 1'b0;
      if (n - last_t >= DEB_L) begin
        differ = 1'b1;
        for (int j = 0; j < DEB_L; j++) if (win[2+j] == stab) differ = 1'b0;
        if (differ) begin stab = !stab; rise_m = stab; last_t = n; end
      end
      mprev = mode_i;
    end
    #1;
    check("model_ce", 32'(ce_o), 32'(exp_ce));
    check("model_rstn", 32'(rstn_o), 32'(exp_rstn));
    check("model_ready", 32'(ready_o), 32'(exp_ready));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int c);
    repeat (c) begin @(posedge clk); #3; end
  endtask

  task automatic edge_to(input longint t);
    while (n < t) begin @(posedge clk); #3; end
  endtask

  task automatic step_pattern(input logic [31:0] pat, input int len, input int tail,
                              output int pulses);
    pulses = 0;
    for (int i = 0; i < len + tail; i++) begin
      step_i = (i < len) ? pat[i] : 1'b0;
      @(posedge clk); #3;
      if (ce_o == 3'b111) pulses++;
    end
  endtask

  longint e0, ee, h, s, r0;
  int     pc;
  logic [31:0] pat;

  initial begin
    // Reset state
    step(3);
    check("reset_rstn", 32'(rstn_o), 32'h0);
    check("reset_ce", 32'(ce_o), 32'h7);
    check("reset_ready", 32'(ready_o), 32'h0);

    // Release sequence
    e0 = n; resetn = 1'b1;
    edge_to(e0 + 9);  check("rel_e9", 32'(rstn_o), 32'h0);
    edge_to(e0 + 10); check("rel_e10", 32'(rstn_o), 32'h1);
    edge_to(e0 + 14); check("rel_e14", 32'(rstn_o), 32'h3);
    edge_to(e0 + 17); check("rel_e17_ready", 32'(ready_o), 32'h0);
    edge_to(e0 + 18); check("rel_e18", 32'(rstn_o), 32'h7);
    check("rel_e18_ready", 32'(ready_o), 32'h1);
    step(2);

    // SLOW with div {5,3,0}
    mode_i = MODE_SLOW; ee = n + 1;
    edge_to(ee + 1);  check("slow_e1", 32'(ce_o), 32'h1);
    edge_to(ee + 3);  check("slow_e3", 32'(ce_o), 32'h3);
    edge_to(ee + 5);  check("slow_e5", 32'(ce_o), 32'h5);
    edge_to(ee + 15); check("slow_e15", 32'(ce_o), 32'h7);
    edge_to(ee + 16); div_i[1*DIV_W +: DIV_W] = 8'd6;
    edge_to(ee + 18); check("div_chg_e18", 32'(ce_o), 32'h3);
    edge_to(ee + 21); check("div_chg_e21", 32'(ce_o), 32'h1);
    edge_to(ee + 24); check("div_chg_e24", 32'(ce_o), 32'h3);

    // HALT
    h = n; mode_i = MODE_HALT;
    edge_to(h + 2); check("halt", 32'(ce_o), 32'h0);

    // Step edge in HALT is discarded and not replayed in STEP
    pat = 32'h0000_00FF;
    step_pattern(pat, 8, 12, pc); check("step_in_halt", 32'(pc), 32'h0);
    mode_i = MODE_STEP; step(2);
    step_pattern(pat, 0, 6, pc); check("step_not_queued", 32'(pc), 32'h0);

    // STEP: short press, clean press, pre-stable glitches, post-stable glitch
    pat = 32'h0000_0007;
    step_pattern(pat, 3, 12, pc); check("step_short", 32'(pc), 32'h0);
    pat = 32'h0000_0FFF;
    step_pattern(pat, 12, 12, pc); check("step_long", 32'(pc), 32'h1);
    pat = 32'h0000_001B;
    step_pattern(pat, 5, 12, pc); check("step_glitch_pre", 32'(pc), 32'h0);
    pat = 32'h0000_0FBF;
    step_pattern(pat, 12, 12, pc); check("step_glitch_post", 32'(pc), 32'h1);

    // Soft reset from ACTIVE
    mode_i = MODE_RUN; step(3);
    soft_rst_i = 1'b1; step(1); s = n; soft_rst_i = 1'b0;
    check("soft_rstn", 32'(rstn_o), 32'h0);
    check("soft_ready", 32'(ready_o), 32'h0);
    check("soft_ce", 32'(ce_o), 32'h7);
    edge_to(s + 7);  check("soft_s7", 32'(rstn_o), 32'h0);
    edge_to(s + 8);  check("soft_s8", 32'(rstn_o), 32'h1);
    edge_to(s + 16); check("soft_s16", 32'(rstn_o), 32'h7);
    check("soft_s16_ready", 32'(ready_o), 32'h1);

    // Asynchronous reset mid-RELEASE with the clock stopped
    step(2);
    soft_rst_i = 1'b1; step(1); s = n; soft_rst_i = 1'b0;
    edge_to(s + 13);
    @(negedge clk); clk_run = 1'b0;
    #1 resetn = 1'b0;
    #2;
    check("async_rstn", 32'(rstn_o), 32'h0);
    check("async_ce", 32'(ce_o), 32'h7);
    check("async_ready", 32'(ready_o), 32'h0);
    #2 resetn = 1'b1; r0 = n;
    #3 clk_run = 1'b1;
    edge_to(r0 + 10); check("rerel_e10", 32'(rstn_o), 32'h1);
    edge_to(r0 + 18); check("rerel_e18_ready", 32'(ready_o), 32'h1);
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", n);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/clock_manager.md
CLOCK_MANAGER -- requirements
Module: clock_manager

Interface
REQ-001 SHALL have parameter NCH, default 2, number of clock-enable/reset channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 16, width of each per-channel divide ratio.
REQ-003 SHALL have parameter HOLD, default 65535, reset hold length in clk cycles (>=1).
REQ-004 SHALL have parameter STAGGER, default 4, cycles between successive channel reset releases (>=1).
REQ-005 SHALL have parameter DEB_W, default 16, debounce counter width; stable time 2^DEB_W cycles.
REQ-006 SHALL have port clk  input  1  design clock, all logic on rising edge.
REQ-007 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-008 SHALL have port mode_i  input  2  00 RUN, 01 SLOW, 10 STEP, 11 HALT.
REQ-009 SHALL have port div_i  input  NCH*DIV_W  per-channel divide ratio, channel k at bits [k*DIV_W +: DIV_W].
REQ-010 SHALL have port step_i  input  1  raw asynchronous single-step button, active-high.
REQ-011 SHALL have port soft_rst_i  input  1  synchronous request to rerun the reset sequence.
REQ-012 SHALL have port ce_o  output  NCH  registered per-channel clock enables.
REQ-013 SHALL have port rstn_o  output  NCH  registered per-channel active-low resets.
REQ-014 SHALL have port ready_o  output  1  high when all rstn_o are released.

Function
REQ-015 Sequencer states SHALL be HOLD, RELEASE, ACTIVE; HOLD->RELEASE when hold counter reaches HOLD, RELEASE->ACTIVE when rstn_o[NCH-1] releases.
REQ-016 resetn deassertion SHALL pass a 2-flop synchroniser; HOLD counting starts on the first edge after the synchronised reset goes high.
REQ-017 rstn_o[0] SHALL rise on exactly the (2+HOLD)th rising edge after resetn rises; rstn_o[k] exactly k*STAGGER edges after rstn_o[0].
REQ-018 ready_o SHALL rise on the same edge as rstn_o[NCH-1] and stay high until the next reset or soft reset.
REQ-019 soft_rst_i sampled high in any state SHALL drive all rstn_o and ready_o low on that edge and enter HOLD with counter cleared; while held high the counter stays cleared; counting resumes on the first edge it is sampled low.
REQ-020 ce_o[k] SHALL be 1 whenever rstn_o[k] is 0, so enable-gated synchronous reset logic observes reset.
REQ-021 For released channels: RUN -> ce_o[k]=1 every cycle; HALT -> ce_o[k]=0.
REQ-022 SLOW -> ce_o[k] SHALL pulse one cycle every D cycles, D = div_i[k] with 0 and 1 both meaning every cycle; per-channel counter of width DIV_W.
REQ-023 div_i[k] SHALL be sampled only when channel k's counter wraps (its pulse cycle) or on SLOW entry; a mid-count change takes effect after the current period.
REQ-024 Entering SLOW from another mode SHALL clear all divider counters; first pulse on channel k comes D cycles after entry.
REQ-025 step_i SHALL pass a 2-flop synchroniser then debouncer: stable value toggles only after synchronised input differs from it for 2^DEB_W consecutive cycles.
REQ-026 STEP -> each stable rising edge of step SHALL give exactly one ce_o pulse, same cycle on all released channels; step edges outside STEP mode or outside ACTIVE SHALL be discarded, not queued.
REQ-027 mode_i changes SHALL take effect on ce_o one edge after being sampled.

Reset
REQ-028 resetn low SHALL asynchronously force rstn_o=0, ready_o=0, ce_o=all ones, state HOLD, all counters and synchroniser/debounce flops 0, without a clk edge.
REQ-029 resetn asserted mid-RELEASE or mid-SLOW period SHALL abort with no partial release retained.

Structure
REQ-030 Package clock_manager_pkg SHALL hold mode encodings (RUN, SLOW, STEP, HALT) and sequencer state encoding.
REQ-031 Synchroniser plus debouncer SHALL be a sub-module step_debounce (parameter DEB_W, outputs stable level and one-cycle rise pulse).

Verification (NCH=3, HOLD=8, STAGGER=4, DEB_W=2)
REQ-032 resetn released at edge 0 -> rstn_o[0] high at edge 10, [1] at 14, [2] at 18 with ready_o; ce_o=111 throughout.
REQ-033 ACTIVE, SLOW, div = {ch2=5, ch1=3, ch0=0} -> ch0 every cycle, ch1 every 3rd, ch2 every 5th cycle after entry.
REQ-034 STEP mode, step_i high 3 cycles -> no pulse; high 12 cycles -> exactly one ce_o=111 pulse; glitches during high produce none extra.
REQ-035 ACTIVE, soft_rst_i one-cycle pulse -> rstn_o=000 and ready_o=0 at that edge; release timing repeats REQ-017 counted from next edge.
REQ-036 resetn low 2 ns mid-RELEASE with clk stopped -> rstn_o=000, ce_o=111 immediately.
REQ-037 SLOW ch1 div 3->6 mid-period -> one more period of 3, then period 6; HALT -> ce_o=000 next edge.
